// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - shared VGA timing defaults, coordinate types and output bundle
package vga_pkg;

  localparam int COORD_W = 10;
  localparam int FRAME_W = 16;

  typedef logic [COORD_W-1:0] coord_t;
  typedef logic [FRAME_W-1:0] frame_cnt_t;

  localparam int H_VISIBLE_DEF = 640;
  localparam int H_FRONT_DEF   = 16;
  localparam int H_SYNC_DEF    = 96;
  localparam int H_BACK_DEF    = 48;
  localparam int V_VISIBLE_DEF = 480;
  localparam int V_FRONT_DEF   = 10;
  localparam int V_SYNC_DEF    = 2;
  localparam int V_BACK_DEF    = 33;

  typedef struct packed {
    logic       hs;
    logic       vs;
    logic       blank;
    logic       line_start;
    logic       frame_start;
    coord_t     draw_x;
    coord_t     draw_y;
    frame_cnt_t frame_count;
  } vga_out_t;

  localparam vga_out_t VGA_OUT_RESET = '{
    hs:          1'b1,
    vs:          1'b1,
    blank:       1'b0,
    line_start:  1'b0,
    frame_start: 1'b0,
    draw_x:      '0,
    draw_y:      '0,
    frame_count: '0
  };

  // Inclusive window test; an empty window (hi < lo) never matches.
  function automatic logic in_window(coord_t c, int lo, int hi);
    return (int'(c) >= lo) && (int'(c) <= hi);
  endfunction

endpackage

// File: rtl/vga_timing_gen_if.sv
// rtl/vga_timing_gen_if.sv - video timing bundle from generator to pixel pipeline
interface vga_timing_gen_if;

  logic                hs;
  logic                vs;
  logic                blank;
  vga_pkg::coord_t     DrawX;
  vga_pkg::coord_t     DrawY;
  logic                line_start;
  logic                frame_start;
  vga_pkg::frame_cnt_t frame_count;

  modport master (
    output hs, vs, blank, DrawX, DrawY, line_start, frame_start, frame_count
  );

  modport slave (
    input  hs, vs, blank, DrawX, DrawY, line_start, frame_start, frame_count
  );

endinterface

// File: rtl/vga_axis_counter.sv
// rtl/vga_axis_counter.sv - one timing axis: wrapping position counter plus sync/visible decode
module vga_axis_counter
  import vga_pkg::*;
#(
  parameter int VISIBLE = H_VISIBLE_DEF,
  parameter int FRONT   = H_FRONT_DEF,
  parameter int SYNC    = H_SYNC_DEF,
  parameter int BACK    = H_BACK_DEF
) (
  input  logic   clk_i,
  input  logic   rst_ni,
  input  logic   en_i,
  output coord_t count_o,
  output logic   first_o,
  output logic   last_o,
  output logic   sync_n_o,
  output logic   visible_o
);

  localparam int TOTAL   = VISIBLE + FRONT + SYNC + BACK;
  localparam int SYNC_LO = VISIBLE + FRONT;
  localparam int SYNC_HI = VISIBLE + FRONT + SYNC - 1;

  coord_t count_q;
  coord_t count_d;

  always_comb begin
    count_d = count_q;
    if (en_i) begin
      count_d = last_o ? '0 : count_q + coord_t'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o   = count_q;
  assign first_o   = (count_q == '0);
  assign last_o    = (count_q == coord_t'(TOTAL - 1));
  assign sync_n_o  = !in_window(count_q, SYNC_LO, SYNC_HI);
  assign visible_o = (int'(count_q) < VISIBLE);

endmodule

// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - VGA raster timing generator with registered, mutually aligned outputs
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int H_VISIBLE = H_VISIBLE_DEF,
  parameter int H_FRONT   = H_FRONT_DEF,
  parameter int H_SYNC    = H_SYNC_DEF,
  parameter int H_BACK    = H_BACK_DEF,
  parameter int V_VISIBLE = V_VISIBLE_DEF,
  parameter int V_FRONT   = V_FRONT_DEF,
  parameter int V_SYNC    = V_SYNC_DEF,
  parameter int V_BACK    = V_BACK_DEF
) (
  input  logic              vga_clk,
  input  logic              reset_n,
  input  logic              pix_en,
  vga_timing_gen_if.master  vga
);

  coord_t     hc;
  coord_t     vc;
  logic       h_first;
  logic       h_last;
  logic       h_sync_n;
  logic       h_vis;
  logic       v_first;
  logic       v_last;
  logic       v_sync_n;
  logic       v_vis;
  logic       v_adv;
  frame_cnt_t frame_cnt_q;
  frame_cnt_t frame_cnt_d;
  vga_out_t   out_q;
  vga_out_t   out_d;

  assign v_adv = pix_en & h_last;

  vga_axis_counter #(
    .VISIBLE (H_VISIBLE),
    .FRONT   (H_FRONT),
    .SYNC    (H_SYNC),
    .BACK    (H_BACK)
  ) u_h_axis (
    .clk_i     (vga_clk),
    .rst_ni    (reset_n),
    .en_i      (pix_en),
    .count_o   (hc),
    .first_o   (h_first),
    .last_o    (h_last),
    .sync_n_o  (h_sync_n),
    .visible_o (h_vis)
  );

  vga_axis_counter #(
    .VISIBLE (V_VISIBLE),
    .FRONT   (V_FRONT),
    .SYNC    (V_SYNC),
    .BACK    (V_BACK)
  ) u_v_axis (
    .clk_i     (vga_clk),
    .rst_ni    (reset_n),
    .en_i      (v_adv),
    .count_o   (vc),
    .first_o   (v_first),
    .last_o    (v_last),
    .sync_n_o  (v_sync_n),
    .visible_o (v_vis)
  );

  // Counts frame completions at the counter wrap; the output stage picks it up
  // on the next enabled cycle so it lines up with frame_start of the new frame.
  always_comb begin
    frame_cnt_d = frame_cnt_q;
    if (v_adv && v_last) begin
      frame_cnt_d = frame_cnt_q + frame_cnt_t'(1);
    end
  end

  always_comb begin
    out_d = out_q;
    if (pix_en) begin
      out_d.hs          = h_sync_n;
      out_d.vs          = v_sync_n;
      out_d.blank       = h_vis & v_vis;
      out_d.line_start  = h_first;
      out_d.frame_start = h_first & v_first;
      out_d.draw_x      = hc;
      out_d.draw_y      = vc;
      out_d.frame_count = frame_cnt_q;
    end
  end

  always_ff @(posedge vga_clk) begin
    if (!reset_n) begin
      frame_cnt_q <= '0;
      out_q       <= VGA_OUT_RESET;
    end else begin
      frame_cnt_q <= frame_cnt_d;
      out_q       <= out_d;
    end
  end

  assign vga.hs          = out_q.hs;
  assign vga.vs          = out_q.vs;
  assign vga.blank       = out_q.blank;
  assign vga.line_start  = out_q.line_start;
  assign vga.frame_start = out_q.frame_start;
  assign vga.DrawX       = out_q.draw_x;
  assign vga.DrawY       = out_q.draw_y;
  assign vga.frame_count = out_q.frame_count;

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb/tb_vga_timing_gen.sv - directed self-checking bench for vga_timing_gen
module tb_vga_timing_gen;

  typedef logic [40:0] vec_t;

  // {hs, vs, blank, line_start, frame_start, DrawX, DrawY, frame_count}
  localparam vec_t RST_V = {5'b11000, 10'd0, 10'd0, 16'd0};

  logic clk;
  logic rst_d_n, en_d;
  logic rst_s_n, en_s;
  logic rst_w_n, en_w;
  int   n_vec   = 0;
  int   n_bad   = 0;
  int   w_edges = 0;
  vec_t act_d, act_s, act_w;

  vga_timing_gen_if if_d ();
  vga_timing_gen_if if_s ();
  vga_timing_gen_if if_w ();

  vga_timing_gen dut_d (
    .vga_clk (clk),
    .reset_n (rst_d_n),
    .pix_en  (en_d),
    .vga     (if_d)
  );

  vga_timing_gen #(
    .H_VISIBLE (8), .H_FRONT (2), .H_SYNC (3), .H_BACK (3),
    .V_VISIBLE (6), .V_FRONT (1), .V_SYNC (2), .V_BACK (3)
  ) dut_s (
    .vga_clk (clk),
    .reset_n (rst_s_n),
    .pix_en  (en_s),
    .vga     (if_s)
  );

  // One-pixel frame: every enabled cycle completes a frame.
  vga_timing_gen #(
    .H_VISIBLE (1), .H_FRONT (0), .H_SYNC (0), .H_BACK (0),
    .V_VISIBLE (1), .V_FRONT (0), .V_SYNC (0), .V_BACK (0)
  ) dut_w (
    .vga_clk (clk),
    .reset_n (rst_w_n),
    .pix_en  (en_w),
    .vga     (if_w)
  );

  assign act_d = {if_d.hs, if_d.vs, if_d.blank, if_d.line_start, if_d.frame_start,
                  if_d.DrawX, if_d.DrawY, if_d.frame_count};
  assign act_s = {if_s.hs, if_s.vs, if_s.blank, if_s.line_start, if_s.frame_start,
                  if_s.DrawX, if_s.DrawY, if_s.frame_count};
  assign act_w = {if_w.hs, if_w.vs, if_w.blank, if_w.line_start, if_w.frame_start,
                  if_w.DrawX, if_w.DrawY, if_w.frame_count};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rst_w_n && en_w) w_edges <= w_edges + 1;
  end

  function automatic vec_t expv(int x, int y, int fc, int hv, int hf, int hsw,
                                int vv, int vf, int vsw);
    logic hs_e, vs_e, bl_e, ls_e, fs_e;
    hs_e = !((x >= hv + hf) && (x <= hv + hf + hsw - 1));
    vs_e = !((y >= vv + vf) && (y <= vv + vf + vsw - 1));
    bl_e = (x < hv) && (y < vv);
    ls_e = (x == 0);
    fs_e = (x == 0) && (y == 0);
    return {hs_e, vs_e, bl_e, ls_e, fs_e, 10'(x), 10'(y), 16'(fc)};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_d_n = 1'b0; en_d = 1'b1;
    rst_s_n = 1'b0; en_s = 1'b1;
    rst_w_n = 1'b0; en_w = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      n_vec++;
      if (act_d !== RST_V) begin n_bad++; $display("FAIL reset_d got %h want %h", act_d, RST_V); end
      n_vec++;
      if (act_s !== RST_V) begin n_bad++; $display("FAIL reset_s got %h want %h", act_s, RST_V); end
      n_vec++;
      if (act_w !== RST_V) begin n_bad++; $display("FAIL reset_w got %h want %h", act_w, RST_V); end
    end
    rst_d_n = 1'b1; en_d = 1'b0;
    rst_s_n = 1'b1; en_s = 1'b0;
    rst_w_n = 1'b1;
    tick();
    n_vec++;
    if (act_d !== RST_V) begin n_bad++; $display("FAIL reset_hold_d got %h want %h", act_d, RST_V); end
    n_vec++;
    if (act_w !== {5'b11111, 10'd0, 10'd0, 16'd0}) begin
      n_bad++; $display("FAIL reset_first_w got %h want %h", act_w, {5'b11111, 10'd0, 10'd0, 16'd0});
    end
  endtask

  task automatic test_first_line();
    vec_t e;
    int   ls_cnt;
    ls_cnt  = 0;
    rst_d_n = 1'b0; en_d = 1'b1;
    tick();
    rst_d_n = 1'b1;
    for (int c = 0; c <= 800; c++) begin
      tick();
      e = expv(c % 800, c / 800, 0, 640, 16, 96, 480, 10, 2);
      n_vec++;
      if (act_d !== e) begin n_bad++; $display("FAIL first_line c=%0d got %h want %h", c, act_d, e); end
      if (if_d.line_start) ls_cnt++;
    end
    n_vec++;
    if (ls_cnt !== 2) begin n_bad++; $display("FAIL line_start_count got %0d want 2", ls_cnt); end
  endtask

  task automatic test_half_rate();
    vec_t e;
    rst_d_n = 1'b0; en_d = 1'b1;
    tick();
    rst_d_n = 1'b1;
    for (int i = 0; i < 1600; i++) begin
      en_d = (i % 2 == 0);
      tick();
      e = expv(i / 2, 0, 0, 640, 16, 96, 480, 10, 2);
      n_vec++;
      if (act_d !== e) begin n_bad++; $display("FAIL half_rate i=%0d got %h want %h", i, act_d, e); end
    end
    en_d = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      e = expv(799, 0, 0, 640, 16, 96, 480, 10, 2);
      n_vec++;
      if (act_d !== e) begin n_bad++; $display("FAIL hold i=%0d got %h want %h", i, act_d, e); end
    end
    en_d = 1'b1;
    tick();
    e = expv(0, 1, 0, 640, 16, 96, 480, 10, 2);
    n_vec++;
    if (act_d !== e) begin n_bad++; $display("FAIL line_wrap got %h want %h", act_d, e); end
    en_d = 1'b0;
  endtask

  task automatic test_full_frame();
    vec_t e;
    int   fs_cnt;
    fs_cnt  = 0;
    rst_s_n = 1'b0; en_s = 1'b1;
    tick();
    rst_s_n = 1'b1;
    for (int c = 0; c <= 192; c++) begin
      tick();
      e = expv(c % 16, (c / 16) % 12, c / 192, 8, 2, 3, 6, 1, 2);
      n_vec++;
      if (act_s !== e) begin n_bad++; $display("FAIL full_frame c=%0d got %h want %h", c, act_s, e); end
      if (if_s.frame_start) fs_cnt++;
    end
    n_vec++;
    if (fs_cnt !== 2) begin n_bad++; $display("FAIL frame_start_count got %0d want 2", fs_cnt); end
    n_vec++;
    if (if_s.frame_count !== 16'd1) begin
      n_bad++; $display("FAIL frame_count_end got %0d want 1", if_s.frame_count);
    end
  endtask

  task automatic test_reset_mid_frame();
    vec_t e;
    for (int c = 193; c <= 262; c++) begin
      tick();
      e = expv(c % 16, (c / 16) % 12, c / 192, 8, 2, 3, 6, 1, 2);
      n_vec++;
      if (act_s !== e) begin n_bad++; $display("FAIL pre_reset c=%0d got %h want %h", c, act_s, e); end
    end
    rst_s_n = 1'b0; en_s = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_vec++;
      if (act_s !== RST_V) begin n_bad++; $display("FAIL mid_reset i=%0d got %h want %h", i, act_s, RST_V); end
    end
    rst_s_n = 1'b1;
    for (int x = 0; x < 2; x++) begin
      tick();
      e = expv(x, 0, 0, 8, 2, 3, 6, 1, 2);
      n_vec++;
      if (act_s !== e) begin n_bad++; $display("FAIL post_reset x=%0d got %h want %h", x, act_s, e); end
    end
  endtask

  task automatic test_frame_wrap();
    int guard;
    guard = 0;
    while (w_edges < 65536 && guard < 80000) begin
      tick();
      guard++;
    end
    n_vec++;
    if (w_edges !== 65536) begin
      n_bad++; $display("FAIL wrap_wait edges got %0d want 65536", w_edges);
    end
    n_vec++;
    if (act_w !== {5'b11111, 10'd0, 10'd0, 16'hffff}) begin
      n_bad++; $display("FAIL wrap_ffff got %h want %h", act_w, {5'b11111, 10'd0, 10'd0, 16'hffff});
    end
    tick();
    n_vec++;
    if (act_w !== {5'b11111, 10'd0, 10'd0, 16'h0000}) begin
      n_bad++; $display("FAIL wrap_zero got %h want %h", act_w, {5'b11111, 10'd0, 10'd0, 16'h0000});
    end
  endtask

  initial begin
    test_reset();
    test_first_line();
    test_half_rate();
    test_full_frame();
    test_reset_mid_frame();
    test_frame_wrap();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
